// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encodings, sweep FSM states, BTB entry layout.
// Entry fields are sized for PCs up to BP_ADDR_W bits and tags for the smallest table (DEPTH=2).
package bp_pkg;
    localparam int BP_ADDR_W    = 32;
    localparam int BP_TAG_MAX_W = BP_ADDR_W - 3;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_MAX_W-1:0] tag;
        logic [BP_ADDR_W-1:0]    target;
        logic [1:0]              cnt;
    } bp_entry_t;
endpackage

// File: rtl/bp_sat_counter.sv
// Combinational 2-bit saturating direction counter next-state; no state, no latency.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);
    always_comb begin
        o_cnt = i_cnt;
        case (i_cnt)
            CNT_SNT: o_cnt = i_taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: o_cnt = i_taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  o_cnt = i_taken ? CNT_ST  : CNT_WNT;
            default: o_cnt = i_taken ? CNT_ST  : CNT_WT;
        endcase
    end
endmodule

// File: rtl/branch_predictor.sv
// BTB with 2-bit direction counters: combinational lookup/mispredict, 1-cycle training, DEPTH-cycle invalidation sweep.
// Optional saturating branch/mispredict statistics when BP_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int TAG_W  = ADDR_W - 2 - IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    input  logic              inval_i,
    output logic              busy_o
`ifdef BP_STATS_EN
   ,output logic [31:0]       stat_branches_o,
    output logic [31:0]       stat_mispred_o
`endif
);
    bp_entry_t        r_entry [DEPTH];
    bp_state_e        r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;

    logic             w_busy;
    logic [IDX_W-1:0] w_lk_idx, w_up_idx;
    logic [TAG_W-1:0] w_lk_tag, w_up_tag;
    bp_entry_t        w_lk_ent, w_up_ent;
    logic             w_lk_hit, w_up_hit, w_upd_en, w_mis;
    logic [1:0]       w_cnt_nxt;

    assign w_busy   = (r_state == SWEEP);
    assign busy_o   = w_busy;

    assign w_lk_idx = lookup_pc_i[IDX_W+1:2];
    assign w_lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign w_lk_ent = r_entry[w_lk_idx];
    assign w_lk_hit = !w_busy && w_lk_ent.valid && w_lk_ent.cnt[1]
                      && (w_lk_ent.tag == BP_TAG_MAX_W'(w_lk_tag));

    assign pred_taken_o  = w_lk_hit;
    assign pred_target_o = w_lk_hit ? w_lk_ent.target[ADDR_W-1:0] : lookup_pc_i + ADDR_W'(4);

    assign w_mis = upd_valid_i && ((upd_taken_i != upd_pred_taken_i)
                   || (upd_taken_i && (upd_target_i != upd_pred_target_i)));
    assign mispredict_o  = w_mis;
    assign redirect_pc_o = !upd_valid_i ? '0 :
                           (upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4));

    // An invalidate request wins over a same-cycle update in IDLE.
    assign w_upd_en = upd_valid_i && (r_state == IDLE) && !inval_i;
    assign w_up_idx = upd_pc_i[IDX_W+1:2];
    assign w_up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign w_up_ent = r_entry[w_up_idx];
    assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == BP_TAG_MAX_W'(w_up_tag));

    bp_sat_counter u_sat_counter (
        .i_cnt   (w_up_ent.cnt),
        .i_taken (upd_taken_i),
        .o_cnt   (w_cnt_nxt)
    );

    // Only the valid bits are reset; tag/target/counter are don't-care while invalid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_entry[i].valid <= 1'b0;
        end else if (w_busy) begin
            r_entry[r_ptr].valid <= 1'b0;
        end else if (w_upd_en) begin
            if (w_up_hit) begin
                r_entry[w_up_idx].cnt <= w_cnt_nxt;
                if (upd_taken_i) r_entry[w_up_idx].target <= BP_ADDR_W'(upd_target_i);
            end else if (upd_taken_i) begin
                r_entry[w_up_idx].valid  <= 1'b1;
                r_entry[w_up_idx].tag    <= BP_TAG_MAX_W'(w_up_tag);
                r_entry[w_up_idx].target <= BP_ADDR_W'(upd_target_i);
                r_entry[w_up_idx].cnt    <= CNT_WT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (inval_i) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                if (inval_i) begin
                    w_ptr_nxt = '0;
                end else if (r_ptr == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_br, r_stat_mp;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else begin
            if (upd_valid_i && (r_stat_br != '1)) r_stat_br <= r_stat_br + 32'd1;
            if (w_mis && (r_stat_mp != '1))       r_stat_mp <= r_stat_mp + 32'd1;
        end
    end

    assign stat_branches_o = r_stat_br;
    assign stat_mispred_o  = r_stat_mp;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then randomized traffic against an array-based model.
module tb_branch_predictor;
    localparam int D = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] lookup_pc_i, upd_pc_i, upd_target_i, upd_pred_target_i;
    logic        upd_valid_i, upd_taken_i, upd_pred_taken_i, inval_i;
    logic        pred_taken_o, mispredict_o, busy_o;
    logic [31:0] pred_target_o, redirect_pc_o;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches_o, stat_mispred_o;
`endif

    always #5 clk_i = ~clk_i;

    branch_predictor dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .lookup_pc_i       (lookup_pc_i),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .mispredict_o      (mispredict_o),
        .redirect_pc_o     (redirect_pc_o),
        .inval_i           (inval_i),
        .busy_o            (busy_o)
`ifdef BP_STATS_EN
       ,.stat_branches_o   (stat_branches_o),
        .stat_mispred_o    (stat_mispred_o)
`endif
    );

    typedef struct {
        int          step;
        logic        pt;
        logic [31:0] ptg;
        logic        mis;
        logic [31:0] rd;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;

    // Reference model: plain per-index arrays, counters as integers 0..3.
    logic        m_valid [D];
    logic [31:0] m_tag   [D];
    logic [31:0] m_tgt   [D];
    int          m_cnt   [D];
    int          m_busy;
    int          m_br, m_mp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got %h expected %h", nm, step_no, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
        m_busy = 0;
        m_br   = 0;
        m_mp   = 0;
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output logic pt, output logic [31:0] tg);
        int i;
        i  = int'((pc / 4) % D);
        pt = (m_busy == 0) && m_valid[i] && (m_tag[i] == pc / (4 * D)) && (m_cnt[i] >= 2);
        tg = pt ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        int i;
        i = int'((pc / 4) % D);
        if (m_valid[i] && m_tag[i] == pc / (4 * D)) begin
            m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            if (tk) m_tgt[i] = tg;
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc / (4 * D);
            m_tgt[i]   = tg;
            m_cnt[i]   = 2;
        end
    endfunction

    // Called at posedge+1: drive one cycle, queue its expectations, then advance the model across the edge.
    task automatic step(input logic [31:0] lpc, input logic uv, input logic [31:0] upc, input logic utk,
                        input logic [31:0] utg, input logic upt, input logic [31:0] uptg, input logic inv);
        exp_t e;
        lookup_pc_i       = lpc;
        upd_valid_i       = uv;
        upd_pc_i          = upc;
        upd_taken_i       = utk;
        upd_target_i      = utg;
        upd_pred_taken_i  = upt;
        upd_pred_target_i = uptg;
        inval_i           = inv;
        step_no++;
        e.step = step_no;
        model_pred(lpc, e.pt, e.ptg);
        e.mis  = uv && ((utk != upt) || (utk && (utg != uptg)));
        e.rd   = !uv ? 32'd0 : (utk ? utg : upc + 32'd4);
        e.busy = (m_busy != 0);
        q.push_back(e);
        @(posedge clk_i);
        if (rst_i) begin
            if (uv) m_br++;
            if (e.mis) m_mp++;
            if (inv) begin
                m_busy = D;
                for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (uv) begin
                model_update(upc, utk, utg);
            end
        end
        #1;
    endtask

    task automatic look(input logic [31:0] lpc);
        step(lpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] lpc, input logic [31:0] upc, input logic tk, input logic [31:0] tg);
        logic        pt;
        logic [31:0] ptg;
        model_pred(upc, pt, ptg);
        step(lpc, 1'b1, upc, tk, tg, pt, ptg, 1'b0);
    endtask

    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pred_taken",  {31'd0, pred_taken_o}, {31'd0, e.pt});
            chk("pred_target", pred_target_o, e.ptg);
            chk("mispredict",  {31'd0, mispredict_o}, {31'd0, e.mis});
            chk("redirect_pc", redirect_pc_o, e.rd);
            chk("busy",        {31'd0, busy_o}, {31'd0, e.busy});
        end
    end

    function automatic logic [31:0] rpc();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, D - 1)) << 2);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        lookup_pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
        upd_target_i = '0; upd_pred_taken_i = 1'b0; upd_pred_target_i = '0; inval_i = 1'b0;
        for (int i = 0; i < D; i++) begin m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0; end
        model_reset();
        @(posedge clk_i); #1;
        look(32'h40);
        rst_i = 1'b1;

        // Training on 0x40; first update also checks no same-cycle bypass.
        step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
        upd(32'h40, 32'h40, 1'b1, 32'h100);
        upd(32'h40, 32'h40, 1'b0, 32'h0);
        upd(32'h40, 32'h40, 1'b0, 32'h0);
        look(32'h40);
        look(32'hFFFF_FFFC);

        // Aliasing: 0x440 shares index 0 with 0x40 and replaces its tag.
        upd(32'h40, 32'h40, 1'b1, 32'h100);
        upd(32'h440, 32'h440, 1'b1, 32'h200);
        look(32'h40);
        look(32'h440);

        // Mispredict: wrong target, then not-taken when predicted taken.
        step(32'h0, 1'b1, 32'h40, 1'b1, 32'h180, 1'b1, 32'h100, 1'b0);
        step(32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);

        // Train four entries, then invalidate with a colliding update and update during sweep.
        for (int k = 0; k < 4; k++) upd(32'h0, 32'h80 + 32'(4 * k), 1'b1, 32'h1000 + 32'(k * 16));
        look(32'h84);
        step(32'h84, 1'b1, 32'h90, 1'b1, 32'h2000, 1'b0, 32'h94, 1'b1);
        for (int k = 0; k < D; k++)
            step(32'h80 + 32'(4 * (k % 4)), 1'b1, 32'hA0, 1'b1, 32'h3000, 1'b0, 32'hA4, 1'b0);
        for (int k = 0; k < 4; k++) look(32'h80 + 32'(4 * k));
        look(32'h90);
        look(32'hA0);

        // Reset in the fifth sweep cycle.
        for (int k = 0; k < 4; k++) upd(32'h0, 32'hC0 + 32'(4 * k), 1'b1, 32'h4000);
        step(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) look(32'hC0);
        rst_i = 1'b0;
        #1;
        chk("busy_async_reset", {31'd0, busy_o}, 32'd0);
        model_reset();
        look(32'hC0);
        rst_i = 1'b1;
        look(32'hC4);

        // Exactly ten resolved branches, three of them mispredicted.
        for (int k = 0; k < 10; k++) begin
            logic        pt;
            logic [31:0] ptg;
            model_pred(32'h200, pt, ptg);
            if (k < 3) step(32'h200, 1'b1, 32'h200, 1'b1, 32'h500, 1'b0, 32'h204, 1'b0);
            else       step(32'h200, 1'b1, 32'h200, 1'b1, 32'h500, pt, ptg, 1'b0);
        end
`ifdef BP_STATS_EN
        chk("stat_branches", stat_branches_o, 32'(m_br));
        chk("stat_mispred",  stat_mispred_o,  32'(m_mp));
`endif

        // Randomized traffic with occasional invalidations.
        for (int k = 0; k < 800; k++) begin
            logic [31:0] lpc, upc, utg, uptg;
            logic        uv, utk, upt, inv;
            lpc  = rpc();
            upc  = rpc();
            uv   = ($urandom_range(0, 3) != 0);
            utk  = 1'($urandom_range(0, 1));
            utg  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 2) != 0) model_pred(upc, upt, uptg);
            else begin
                upt  = 1'($urandom_range(0, 1));
                uptg = $urandom & 32'hFFFF_FFFC;
            end
            inv = ($urandom_range(0, 99) == 0);
            step(lpc, uv, upc, utk, utg, upt, uptg, inv);
        end
`ifdef BP_STATS_EN
        chk("stat_branches_final", stat_branches_o, 32'(m_br));
        chk("stat_mispred_final",  stat_mispred_o,  32'(m_mp));
`endif

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk_i);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
